// File: rtl/branch_pc_unit_if.sv
// rtl/branch_pc_unit_if.sv - EX-stage resolution and fetch-PC bundle for branch_pc_unit
interface branch_pc_unit_if #(
    parameter int CNT_W = 32
);
    logic             i_stall;
    logic             i_ex_valid;
    logic [31:0]      i_ex_pc;
    logic             i_ex_is_br;
    logic             i_ex_is_jal;
    logic             i_ex_is_jalr;
    logic [2:0]       i_ex_funct3;
    logic [31:0]      i_ex_target;
    logic             i_br_less;
    logic             i_br_equal;
    logic             o_br_un;
    logic [31:0]      o_pc;
    logic [31:0]      o_pc_four;
    logic             o_taken;
    logic             o_flush;
    logic             o_halt;
    logic [31:0]      o_fault_pc;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_taken_cnt;

    // master is the pipeline side driving EX info; slave is the PC unit.
    modport master (
        output i_stall, i_ex_valid, i_ex_pc, i_ex_is_br, i_ex_is_jal, i_ex_is_jalr,
               i_ex_funct3, i_ex_target, i_br_less, i_br_equal,
        input  o_br_un, o_pc, o_pc_four, o_taken, o_flush, o_halt, o_fault_pc,
               o_br_cnt, o_taken_cnt
    );

    modport slave (
        input  i_stall, i_ex_valid, i_ex_pc, i_ex_is_br, i_ex_is_jal, i_ex_is_jalr,
               i_ex_funct3, i_ex_target, i_br_less, i_br_equal,
        output o_br_un, o_pc, o_pc_four, o_taken, o_flush, o_halt, o_fault_pc,
               o_br_cnt, o_taken_cnt
    );
endinterface

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - branch resolution, fetch-PC sequencer, halt-on-misalign and branch stats
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    branch_pc_unit_if.slave   bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      fault_q, fault_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic        cond;
    logic        legal;
    logic [31:0] eff_target;
    logic        req;
    logic        misaligned;
    logic        taken;
    logic        flush;
    logic        count_br;

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        unique case (bus.i_ex_funct3)
            3'b000:          cond = bus.i_br_equal;
            3'b001:          cond = ~bus.i_br_equal;
            3'b100, 3'b110:  cond = bus.i_br_less;
            3'b101, 3'b111:  cond = ~bus.i_br_less;
            default:         legal = 1'b0;
        endcase

        eff_target = bus.i_ex_target;
        if (bus.i_ex_is_jalr) begin
            eff_target[0] = 1'b0;
        end

        req        = bus.i_ex_valid & (bus.i_ex_is_jal | bus.i_ex_is_jalr |
                                       (bus.i_ex_is_br & cond));
        misaligned = req & (eff_target[1:0] != 2'b00);
        count_br   = bus.i_ex_valid & bus.i_ex_is_br & legal;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fault_d     = fault_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        taken       = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            RUN: begin
                flush = req;
                taken = req & ~misaligned;

                // Counters saturate so long runs never report a small, wrapped count.
                if (count_br && (br_cnt_q != {CNT_W{1'b1}})) begin
                    br_cnt_d = br_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (count_br && cond && (taken_cnt_q != {CNT_W{1'b1}})) begin
                    taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end

                // A redirect beats a stall: the stalled instruction is younger and gets flushed.
                if (misaligned) begin
                    state_d = HALT;
                    fault_d = bus.i_ex_pc;
                end else if (req) begin
                    pc_d = eff_target;
                end else if (!bus.i_stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            HALT: begin
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            fault_q     <= 32'h0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fault_q     <= fault_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.o_br_un     = bus.i_ex_funct3[1];
    assign bus.o_pc        = pc_q;
    assign bus.o_pc_four   = pc_q + 32'd4;
    assign bus.o_taken     = taken;
    assign bus.o_flush     = flush;
    assign bus.o_halt      = (state_q == HALT);
    assign bus.o_fault_pc  = fault_q;
    assign bus.o_br_cnt    = br_cnt_q;
    assign bus.o_taken_cnt = taken_cnt_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit with a cycle-level reference model
module tb_branch_pc_unit;
    localparam int          CW    = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          SATV  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_pc_unit_if #(.CNT_W(CW)) bus ();

    branch_pc_unit #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        br_un;
        logic [31:0] pc;
        logic [31:0] pc_four;
        logic        taken;
        logic        flush;
        logic        halt;
        logic [31:0] fault;
        int          bc;
        int          tc;
    } exp_t;

    exp_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    // Reference state: what the registers will hold after the next edge.
    bit          m_known = 0;
    bit          m_halt;
    logic [31:0] m_pc;
    logic [31:0] m_fault;
    int          m_bc;
    int          m_tc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 none, 1 branch, 2 jal, 3 jalr
    task automatic cycle(input bit r, input bit stall, input bit valid, input int kind,
                         input logic [2:0] f3, input logic [31:0] epc, input logic [31:0] tgt,
                         input bit less, input bit equal);
        bit cond, legal, req, mis, is_br;
        logic [31:0] eff;
        exp_t e;
        rst                = r;
        bus.i_stall        = stall;
        bus.i_ex_valid     = valid;
        bus.i_ex_pc        = epc;
        bus.i_ex_is_br     = (kind == 1);
        bus.i_ex_is_jal    = (kind == 2);
        bus.i_ex_is_jalr   = (kind == 3);
        bus.i_ex_funct3    = f3;
        bus.i_ex_target    = tgt;
        bus.i_br_less      = less;
        bus.i_br_equal     = equal;

        is_br = (kind == 1);
        legal = !(f3 == 3'd2 || f3 == 3'd3);
        case (f3)
            3'd0:       cond = equal;
            3'd1:       cond = !equal;
            3'd4, 3'd6: cond = less;
            3'd5, 3'd7: cond = !less;
            default:    cond = 0;
        endcase
        eff = (kind == 3) ? (tgt & 32'hFFFF_FFFE) : tgt;
        req = valid && (kind == 2 || kind == 3 || (is_br && cond));
        mis = req && (eff % 4 != 0);

        if (m_known) begin
            e.br_un   = f3[1];
            e.pc      = m_pc;
            e.pc_four = m_pc + 32'd4;
            e.taken   = !m_halt && req && !mis;
            e.flush   = !m_halt && req;
            e.halt    = m_halt;
            e.fault   = m_fault;
            e.bc      = m_bc;
            e.tc      = m_tc;
            exp_q.push_back(e);
        end

        if (r) begin
            m_known = 1; m_halt = 0; m_pc = RPC; m_fault = 0; m_bc = 0; m_tc = 0;
        end else if (m_known && !m_halt) begin
            if (valid && is_br && legal) begin
                m_bc = (m_bc + 1 > SATV) ? SATV : m_bc + 1;
                if (cond) m_tc = (m_tc + 1 > SATV) ? SATV : m_tc + 1;
            end
            if (mis) begin
                m_halt = 1; m_fault = epc;
            end else if (req) begin
                m_pc = eff;
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit stall);
        for (int k = 0; k < n; k++) cycle(0, stall, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0);
    endtask

    // Monitor: combinational outputs are stable well before the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("br_un",     32'(bus.o_br_un),     32'(e.br_un));
                chk("pc",        bus.o_pc,             e.pc);
                chk("pc_four",   bus.o_pc_four,        e.pc_four);
                chk("taken",     32'(bus.o_taken),     32'(e.taken));
                chk("flush",     32'(bus.o_flush),     32'(e.flush));
                chk("halt",      32'(bus.o_halt),      32'(e.halt));
                chk("fault_pc",  bus.o_fault_pc,       e.fault);
                chk("br_cnt",    32'(bus.o_br_cnt),    32'(e.bc));
                chk("taken_cnt", 32'(bus.o_taken_cnt), 32'(e.tc));
            end
        end
    end

    initial begin
        logic [31:0] rnd_a, rnd_b;
        logic [31:0] tgt;
        logic [2:0]  f3;
        rst = 1'b1;
        bus.i_stall = 0; bus.i_ex_valid = 0; bus.i_ex_pc = 0; bus.i_ex_is_br = 0;
        bus.i_ex_is_jal = 0; bus.i_ex_is_jalr = 0; bus.i_ex_funct3 = 0; bus.i_ex_target = 0;
        bus.i_br_less = 0; bus.i_br_equal = 0;
        @(posedge clk);
        #1;

        // Reset and sequential fetch
        cycle(1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        idle(3, 0);
        chk("seq_pc_after_3", bus.o_pc, 32'h10C);

        // Signed vs unsigned compare
        cycle(0, 0, 1, 1, 3'b100, 32'h10C, 32'h200, 1, 0);
        cycle(0, 0, 1, 1, 3'b111, 32'h110, 32'h500, 1, 0);
        chk("blt_target_pc", bus.o_pc, 32'h204);

        // JALR clears bit 0
        cycle(0, 0, 1, 3, 3'b000, 32'h204, 32'h301, 0, 0);
        chk("jalr_pc", bus.o_pc, 32'h300);

        // Redirect overrides stall, then stall alone holds
        cycle(0, 1, 1, 1, 3'b000, 32'h300, 32'h40, 0, 1);
        idle(2, 1);
        chk("stall_hold_pc", bus.o_pc, 32'h40);

        // Misaligned target halts; later branches are ignored
        cycle(0, 0, 1, 1, 3'b001, 32'h3F0, 32'h402, 0, 0);
        idle(5, 0);
        cycle(0, 0, 1, 1, 3'b000, 32'h500, 32'h800, 0, 1);
        chk("fault_pc", bus.o_fault_pc, 32'h3F0);
        chk("halt_set", 32'(bus.o_halt), 32'd1);
        cycle(1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        chk("reset_pc", bus.o_pc, RPC);

        // Illegal funct3 not counted, then saturation
        cycle(0, 0, 1, 1, 3'b010, 32'h100, 32'h600, 1, 1);
        chk("illegal_f3_cnt", 32'(bus.o_br_cnt), 32'd0);
        for (int k = 0; k < 17; k++)
            cycle(0, 0, 1, 1, 3'b000, 32'h1000, 32'h1000 + 32'(k * 8), 0, 1);
        chk("sat_br_cnt", 32'(bus.o_br_cnt), 32'd15);
        chk("sat_taken_cnt", 32'(bus.o_taken_cnt), 32'd15);

        // PC wrap
        cycle(0, 0, 1, 2, 3'b000, 32'h2000, 32'hFFFF_FFFC, 0, 0);
        idle(1, 0);
        chk("pc_wrap", bus.o_pc, 32'h0);

        // Randomized traffic
        cycle(1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            rnd_a = $urandom;
            rnd_b = $urandom;
            tgt = {rnd_a[31:2], 2'b00};
            if (rnd_b[2:0] == 3'd0) tgt[1:0] = rnd_b[4:3];
            if (rnd_b[7:5] == 3'd1) tgt[0] = 1'b1;
            f3 = rnd_b[10:8];
            cycle(($urandom_range(0, 39) == 0), rnd_b[11], rnd_b[12] | rnd_b[13],
                  int'($urandom_range(0, 3)), f3, $urandom, tgt, rnd_b[14], rnd_b[15]);
        end

        idle(2, 0);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
